arp_ipv4_mac_cam_ram_init: RTL and testbench

Parametrised 1RW+1W block RAM for the ARP IPv4→MAC CAM, successor to the plain two-port lookup/update RAM. It adds:
- self-clearing of every entry after reset or on request
- an optional output register stage
- a read-data valid strobe
- deterministic write-write collision arbitration with a saturating collision counter

It sits between the ARP CAM lookup/learn engine (RW port) and the management/host update path (W port).

---
 rtl/arp_ipv4_mac_cam_ram_init.sv | 157 +++++++++++++++
 tb/tb_arp_ipv4_mac_cam_ram_init.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_ipv4_mac_cam_ram_init.sv
// ARP IPv4->MAC CAM storage: 1RW + 1W block RAM with self-clear after reset
// or on request, optional output register, read-valid strobe and
// write-write collision arbitration with a saturating collision counter.
//
// state | meaning
// INIT  | clear sequence, one INIT_VAL write per cycle, port requests dropped
// RUN   | normal RW-port and W-port access
module arp_ipv4_mac_cam_ram_init #(
    parameter int           A        = 9,
    parameter int           D        = 64,
    parameter int           OREG     = 0,
    parameter logic [D-1:0] INIT_VAL = {D{1'b0}}
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         RwEnb,
    input  logic         RwWe,
    input  logic [A-1:0] RwAddr,
    input  logic [D-1:0] RwData,
    output logic [D-1:0] RwDataOut,
    output logic         RwDataVld,
    input  logic         WrEnb,
    input  logic [A-1:0] WrAddr,
    input  logic [D-1:0] WrData,
    input  logic         InitReq,
    output logic         InitBusy,
    output logic         Collision,
    output logic [15:0]  CollisionCnt
);

    localparam int DEPTH = 1 << A;

    typedef enum logic {INIT, RUN} stateT;

    stateT          stateQ, stateD;
    logic [A-1:0]   initAddrQ, initAddrD;
    logic           accept;
    logic           rwAcc;
    logic           rwWr;
    logic           wWr;
    logic           colEvt;
    logic [D-1:0]   mem [DEPTH];
    logic [D-1:0]   rdQ;
    logic           rdVldQ;

    // Next-state, clear-address advance and port arbitration
    always_comb begin
        stateD    = stateQ;
        initAddrD = initAddrQ;
        // InitReq wins over any access presented in the same cycle
        accept    = (stateQ == RUN) && !InitReq;
        rwAcc     = accept && RwEnb;
        rwWr      = rwAcc && RwWe;
        // Only a write-write hit on one address is a collision; RW wins
        colEvt    = rwWr && WrEnb && (RwAddr == WrAddr);
        wWr       = accept && WrEnb && !colEvt;
        case (stateQ)
            INIT: begin
                if (&initAddrQ) begin
                    stateD = RUN;
                end else begin
                    initAddrD = initAddrQ + A'(1);
                end
            end
            RUN: begin
                if (InitReq) begin
                    stateD    = INIT;
                    initAddrD = '0;
                end
            end
            default: begin
                stateD    = INIT;
                initAddrD = '0;
            end
        endcase
    end

    // State and clear-address registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stateQ    <= INIT;
            initAddrQ <= '0;
        end else begin
            stateQ    <= stateD;
            initAddrQ <= initAddrD;
        end
    end

    assign InitBusy = (stateQ == INIT);

    // RAM array writes; contents are defined by the clear sequence, not by reset
    always_ff @(posedge Clk) begin
        if (stateQ == INIT) begin
            mem[initAddrQ] <= INIT_VAL;
        end else begin
            if (wWr) begin
                mem[WrAddr] <= WrData;
            end
            if (rwWr) begin
                mem[RwAddr] <= RwData;
            end
        end
    end

    // Read-first RW-port read stage; data holds while no read is accepted
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rdQ    <= '0;
            rdVldQ <= 1'b0;
        end else begin
            rdVldQ <= rwAcc;
            if (rwAcc) begin
                rdQ <= mem[RwAddr];
            end
        end
    end

    generate
        if (OREG != 0) begin : gOreg
            logic [D-1:0] oregQ;
            logic         oregVldQ;

            // Extra output register; only loads when the first stage is valid
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    oregQ    <= '0;
                    oregVldQ <= 1'b0;
                end else begin
                    oregVldQ <= rdVldQ;
                    if (rdVldQ) begin
                        oregQ <= rdQ;
                    end
                end
            end

            assign RwDataOut = oregQ;
            assign RwDataVld = oregVldQ;
        end else begin : gNoOreg
            assign RwDataOut = rdQ;
            assign RwDataVld = rdVldQ;
        end
    endgenerate

    // Collision pulse and saturating count; only reset clears them
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Collision    <= 1'b0;
            CollisionCnt <= '0;
        end else begin
            Collision <= colEvt;
            if (colEvt && (CollisionCnt != 16'hFFFF)) begin
                CollisionCnt <= CollisionCnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_arp_ipv4_mac_cam_ram_init.sv
// Bench for arp_ipv4_mac_cam_ram_init: two instances (no output register and
// output register) share stimulus and are checked against an array model.
module tb_arp_ipv4_mac_cam_ram_init;

    localparam int          A     = 4;
    localparam int          D     = 64;
    localparam int          DEPTH = 16;
    localparam logic [63:0] IV    = 64'h5A5A_0F0F_C3C3_0001;

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          RwEnb = 1'b0;
    logic          RwWe = 1'b0;
    logic [A-1:0]  RwAddr = '0;
    logic [D-1:0]  RwData = '0;
    logic          WrEnb = 1'b0;
    logic [A-1:0]  WrAddr = '0;
    logic [D-1:0]  WrData = '0;
    logic          InitReq = 1'b0;

    logic [D-1:0]  RwDataOut0, RwDataOut1;
    logic          RwDataVld0, RwDataVld1;
    logic          InitBusy0, InitBusy1;
    logic          Collision0, Collision1;
    logic [15:0]   CollisionCnt0, CollisionCnt1;

    int checks = 0;
    int fails  = 0;

    // Reference model
    logic [63:0] mMem [DEPTH];
    int          mClearLeft;
    int          mColCnt;
    bit          mCol;
    bit          mVld0, mVld1, pVld;
    logic [63:0] mData0, mData1, pData;

    arp_ipv4_mac_cam_ram_init #(.A(A), .D(D), .OREG(0), .INIT_VAL(IV)) u_dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .RwEnb(RwEnb), .RwWe(RwWe), .RwAddr(RwAddr),
        .RwData(RwData), .RwDataOut(RwDataOut0), .RwDataVld(RwDataVld0),
        .WrEnb(WrEnb), .WrAddr(WrAddr), .WrData(WrData), .InitReq(InitReq),
        .InitBusy(InitBusy0), .Collision(Collision0), .CollisionCnt(CollisionCnt0)
    );

    arp_ipv4_mac_cam_ram_init #(.A(A), .D(D), .OREG(1), .INIT_VAL(IV)) u_dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .RwEnb(RwEnb), .RwWe(RwWe), .RwAddr(RwAddr),
        .RwData(RwData), .RwDataOut(RwDataOut1), .RwDataVld(RwDataVld1),
        .WrEnb(WrEnb), .WrAddr(WrAddr), .WrData(WrData), .InitReq(InitReq),
        .InitBusy(InitBusy1), .Collision(Collision1), .CollisionCnt(CollisionCnt1)
    );

    always #5 Clk = ~Clk;

    // Present one cycle of stimulus, advance the model over that edge, and
    // return 1 time unit after the edge with inputs idle again.
    task automatic step(input bit re, input bit rw, input logic [3:0] ra, input logic [63:0] rd,
                        input bit we, input logic [3:0] wa, input logic [63:0] wd, input bit ir);
        bit          newVld;
        bit          col;
        logic [63:0] newData;
        RwEnb = re; RwWe = rw; RwAddr = ra; RwData = rd;
        WrEnb = we; WrAddr = wa; WrData = wd; InitReq = ir;
        newVld = 0; col = 0; newData = '0;
        if (mClearLeft > 0) begin
            mMem[DEPTH - mClearLeft] = IV;
            mClearLeft--;
        end else if (ir) begin
            mClearLeft = DEPTH;
        end else begin
            if (re) begin
                newVld  = 1;
                newData = mMem[ra];
            end
            col = re && rw && we && (ra == wa);
            if (we && !col) mMem[wa] = wd;
            if (re && rw) mMem[ra] = rd;
            if (col && mColCnt < 65535) mColCnt++;
        end
        mCol  = col;
        mVld1 = pVld;
        if (pVld) mData1 = pData;
        pVld = newVld;
        if (newVld) pData = newData;
        mVld0 = newVld;
        if (newVld) mData0 = newData;
        @(posedge Clk);
        #1;
        RwEnb = 0; RwWe = 0; WrEnb = 0; InitReq = 0;
    endtask

    task automatic idle();
        step(0, 0, 4'd0, 64'd0, 0, 4'd0, 64'd0, 0);
    endtask

    task automatic rstAssert();
        Rst_n = 0;
        mClearLeft = DEPTH; mColCnt = 0; mCol = 0;
        mVld0 = 0; mVld1 = 0; pVld = 0; mData0 = '0; mData1 = '0; pData = '0;
        #2;
    endtask

    task automatic rstRelease();
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Rst_n = 1;
    endtask

    task automatic fillRandom();
        for (int a = 0; a < DEPTH; a++) begin
            step(0, 0, 4'd0, 64'd0, 1, a[3:0], {$urandom, $urandom} | 64'h1, 0);
        end
    endtask

    task automatic test_reset();
        rstAssert();
        checks++;
        if ({RwDataOut0, RwDataVld0, InitBusy0, Collision0, CollisionCnt0} !== {64'h0, 1'b0, 1'b1, 1'b0, 16'h0}) begin
            fails++;
            $display("FAIL reset_dut0: got out=%h vld=%b busy=%b col=%b cnt=%h, want 0/0/1/0/0",
                     RwDataOut0, RwDataVld0, InitBusy0, Collision0, CollisionCnt0);
        end
        checks++;
        if ({RwDataOut1, RwDataVld1, InitBusy1, Collision1, CollisionCnt1} !== {64'h0, 1'b0, 1'b1, 1'b0, 16'h0}) begin
            fails++;
            $display("FAIL reset_dut1: got out=%h vld=%b busy=%b col=%b cnt=%h, want 0/0/1/0/0",
                     RwDataOut1, RwDataVld1, InitBusy1, Collision1, CollisionCnt1);
        end
        rstRelease();
        begin
            int busy = 0;
            while (InitBusy0 && busy < 40) begin
                idle();
                busy++;
            end
            checks++;
            if (busy != DEPTH || InitBusy1 !== 1'b0) begin
                fails++;
                $display("FAIL reset_busy_len: got %0d cycles (dut1 busy=%b), want %0d", busy, InitBusy1, DEPTH);
            end
        end
    endtask

    task automatic test_init_readback();
        for (int a = 0; a <= DEPTH; a++) begin
            if (a < DEPTH) step(1, 0, a[3:0], 64'd0, 0, 4'd0, 64'd0, 0);
            else idle();
            checks++;
            if ({RwDataVld0, RwDataOut0} !== {mVld0, mData0}) begin
                fails++;
                $display("FAIL init_rd_lat1 a=%0d: got %b/%h want %b/%h", a, RwDataVld0, RwDataOut0, mVld0, mData0);
            end
            checks++;
            if ({RwDataVld1, RwDataOut1} !== {mVld1, mData1}) begin
                fails++;
                $display("FAIL init_rd_lat2 a=%0d: got %b/%h want %b/%h", a, RwDataVld1, RwDataOut1, mVld1, mData1);
            end
        end
    endtask

    task automatic test_wport_rw();
        step(0, 0, 4'd0, 64'd0, 1, 4'd5, 64'hDEAD_BEEF_0000_0001, 0);
        step(1, 0, 4'd5, 64'd0, 0, 4'd0, 64'd0, 0);
        checks++;
        if ({RwDataVld0, RwDataOut0} !== {1'b1, 64'hDEAD_BEEF_0000_0001}) begin
            fails++;
            $display("FAIL wport_read: got %b/%h want 1/deadbeef00000001", RwDataVld0, RwDataOut0);
        end
        step(1, 1, 4'd5, 64'h2, 0, 4'd0, 64'd0, 0);
        checks++;
        if ({RwDataVld0, RwDataOut0, RwDataVld1, RwDataOut1} !==
            {1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, 64'hDEAD_BEEF_0000_0001}) begin
            fails++;
            $display("FAIL read_first: got %b/%h %b/%h want old value on both", RwDataVld0, RwDataOut0, RwDataVld1, RwDataOut1);
        end
        step(1, 0, 4'd5, 64'd0, 0, 4'd0, 64'd0, 0);
        checks++;
        if ({RwDataVld0, RwDataOut0} !== {1'b1, 64'h2}) begin
            fails++;
            $display("FAIL rw_written: got %b/%h want 1/2", RwDataVld0, RwDataOut0);
        end
        idle();
        checks++;
        if ({RwDataVld0, RwDataOut0, RwDataVld1, RwDataOut1} !== {1'b0, 64'h2, 1'b1, 64'h2}) begin
            fails++;
            $display("FAIL hold_and_lat2: got %b/%h %b/%h want 0/2 1/2", RwDataVld0, RwDataOut0, RwDataVld1, RwDataOut1);
        end
    endtask

    task automatic test_collision();
        step(1, 1, 4'd3, 64'hA, 1, 4'd3, 64'hB, 0);
        checks++;
        if ({Collision0, CollisionCnt0, Collision1, CollisionCnt1} !== {1'b1, 16'd1, 1'b1, 16'd1}) begin
            fails++;
            $display("FAIL collision_pulse: got %b/%0d %b/%0d want 1/1", Collision0, CollisionCnt0, Collision1, CollisionCnt1);
        end
        step(1, 0, 4'd3, 64'd0, 1, 4'd3, 64'hC, 0);
        checks++;
        if ({Collision0, CollisionCnt0, RwDataVld0, RwDataOut0} !== {1'b0, 16'd1, 1'b1, 64'hA}) begin
            fails++;
            $display("FAIL collision_winner: got col=%b cnt=%0d %b/%h want 0/1 1/a", Collision0, CollisionCnt0, RwDataVld0, RwDataOut0);
        end
        step(1, 0, 4'd3, 64'd0, 0, 4'd0, 64'd0, 0);
        checks++;
        if ({Collision0, RwDataVld0, RwDataOut0} !== {1'b0, 1'b1, 64'hC}) begin
            fails++;
            $display("FAIL read_vs_write: got col=%b %b/%h want 0 1/c", Collision0, RwDataVld0, RwDataOut0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 3)), {$urandom, $urandom},
                 $urandom_range(0, 1), 4'($urandom_range(0, 3)), {$urandom, $urandom}, ($urandom_range(0, 49) == 0));
            checks++;
            if ({RwDataVld0, RwDataOut0, RwDataVld1, RwDataOut1} !== {mVld0, mData0, mVld1, mData1}) begin
                fails++;
                $display("FAIL random_rd i=%0d: got %b/%h %b/%h want %b/%h %b/%h", i,
                         RwDataVld0, RwDataOut0, RwDataVld1, RwDataOut1, mVld0, mData0, mVld1, mData1);
            end
            checks++;
            if ({InitBusy0, Collision0, CollisionCnt0, InitBusy1, Collision1, CollisionCnt1} !==
                {(mClearLeft > 0), mCol, 16'(mColCnt), (mClearLeft > 0), mCol, 16'(mColCnt)}) begin
                fails++;
                $display("FAIL random_status i=%0d: got busy=%b col=%b cnt=%0d want %b/%b/%0d", i,
                         InitBusy0, Collision0, CollisionCnt0, (mClearLeft > 0), mCol, mColCnt);
            end
        end
        while (mClearLeft > 0) idle();
    endtask

    task automatic test_initreq();
        int busy;
        fillRandom();
        step(1, 0, 4'd1, 64'd0, 1, 4'd2, 64'h1234, 0);
        step(0, 0, 4'd0, 64'd0, 1, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        checks++;
        if ({InitBusy0, RwDataVld0, RwDataVld1, RwDataOut1} !== {1'b1, 1'b0, 1'b1, mData1}) begin
            fails++;
            $display("FAIL initreq_edge: got busy=%b vld0=%b vld1=%b out1=%h want 1/0/1/%h",
                     InitBusy0, RwDataVld0, RwDataVld1, RwDataOut1, mData1);
        end
        busy = 0;
        while (InitBusy0 && busy < 40) begin
            step(1, $urandom_range(0, 1), 4'($urandom_range(0, 15)), {$urandom, $urandom},
                 1, 4'($urandom_range(0, 15)), {$urandom, $urandom}, $urandom_range(0, 1));
            busy++;
            checks++;
            if (RwDataVld0 !== 1'b0 || Collision0 !== 1'b0) begin
                fails++;
                $display("FAIL busy_request_dropped: got vld=%b col=%b want 0/0", RwDataVld0, Collision0);
            end
        end
        checks++;
        if (busy != DEPTH) begin
            fails++;
            $display("FAIL initreq_busy_len: got %0d want %0d", busy, DEPTH);
        end
        for (int a = 0; a <= DEPTH; a++) begin
            if (a < DEPTH) step(1, 0, a[3:0], 64'd0, 0, 4'd0, 64'd0, 0);
            else idle();
            checks++;
            if ({RwDataVld0, RwDataOut0, RwDataVld1, RwDataOut1} !== {mVld0, mData0, mVld1, mData1}) begin
                fails++;
                $display("FAIL initreq_readback a=%0d: got %b/%h %b/%h want %b/%h %b/%h", a,
                         RwDataVld0, RwDataOut0, RwDataVld1, RwDataOut1, mVld0, mData0, mVld1, mData1);
            end
        end
        checks++;
        if (CollisionCnt0 !== 16'(mColCnt) || mColCnt == 0) begin
            fails++;
            $display("FAIL initreq_cnt_kept: got %0d want %0d (nonzero)", CollisionCnt0, mColCnt);
        end
    endtask

    task automatic test_reset_mid();
        int busy;
        for (int pass = 0; pass < 2; pass++) begin
            fillRandom();
            if (pass == 0) begin
                step(1, 0, 4'd2, 64'd0, 0, 4'd0, 64'd0, 0);
            end else begin
                step(0, 0, 4'd0, 64'd0, 0, 4'd0, 64'd0, 1);
                for (int i = 0; i < 7; i++) idle();
            end
            rstAssert();
            checks++;
            if ({RwDataOut0, RwDataVld0, RwDataOut1, RwDataVld1, InitBusy0, CollisionCnt0} !==
                {64'h0, 1'b0, 64'h0, 1'b0, 1'b1, 16'h0}) begin
                fails++;
                $display("FAIL mid_reset_outputs pass=%0d: got %h/%b %h/%b busy=%b cnt=%0d want zeros, busy 1", pass,
                         RwDataOut0, RwDataVld0, RwDataOut1, RwDataVld1, InitBusy0, CollisionCnt0);
            end
            rstRelease();
            busy = 0;
            while (InitBusy1 && busy < 40) begin
                idle();
                busy++;
            end
            checks++;
            if (busy != DEPTH) begin
                fails++;
                $display("FAIL mid_reset_busy_len pass=%0d: got %0d want %0d", pass, busy, DEPTH);
            end
            for (int a = 0; a < DEPTH; a++) begin
                step(1, 0, a[3:0], 64'd0, 0, 4'd0, 64'd0, 0);
                checks++;
                if ({RwDataVld0, RwDataOut0} !== {1'b1, IV}) begin
                    fails++;
                    $display("FAIL mid_reset_readback pass=%0d a=%0d: got %b/%h want 1/%h", pass, a, RwDataVld0, RwDataOut0, IV);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [3:0] ad;
        rstAssert();
        rstRelease();
        while (mClearLeft > 0) idle();
        for (int i = 0; i < 65540; i++) begin
            ad = 4'($urandom_range(0, 15));
            step(1, 1, ad, {$urandom, $urandom}, 1, ad, {$urandom, $urandom}, 0);
            if (i == 65533) begin
                checks++;
                if (CollisionCnt0 !== 16'hFFFE) begin
                    fails++;
                    $display("FAIL sat_before: got %h want fffe", CollisionCnt0);
                end
            end
        end
        checks++;
        if ({Collision0, CollisionCnt0, Collision1, CollisionCnt1} !== {1'b1, 16'hFFFF, 1'b1, 16'hFFFF}) begin
            fails++;
            $display("FAIL sat_after: got %b/%h %b/%h want 1/ffff", Collision0, CollisionCnt0, Collision1, CollisionCnt1);
        end
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) mMem[a] = '0;
        #3;
        test_reset();
        test_init_readback();
        test_wport_rw();
        test_collision();
        test_random();
        test_initreq();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
